// File: rtl/alu_sched_pkg.sv
// Shared opcodes, FSM state and command record for the round-robin ALU scheduler.
package alu_sched_pkg;

    localparam logic [2:0] OP_NOT = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_CUT = 3'd6;
    localparam logic [2:0] OP_ADD = 3'd7;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
    } alu_cmd_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the requesters, the consumer and the scheduler.
interface alu_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [3*NUM_REQ-1:0]  req_opcode;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_cin;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_cout;
    logic [CNT_W-1:0]      op_count;

    modport master (
        output req_valid, req_opcode, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_cout, op_count
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_cout, op_count
    );

endinterface

// File: rtl/alu_32bit_unsigned.sv
// Combinational 32-bit unsigned ALU; shift amount is b[4:0], carry-out only from ADD.
module alu_32bit_unsigned
    import alu_sched_pkg::*;
(
    input  logic [2:0]  opcode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] result,
    output logic        cout
);
    logic [4:0] n;

    assign n = b[4:0];

    always_comb begin
        result = '0;
        cout   = 1'b0;
        case (opcode)
            OP_NOT: result = ~a;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: result = a << n;
            OP_SHR: result = a >> n;
            // keep the low n bits of a; n=0 leaves nothing
            OP_CUT: result = a & ~(32'hFFFF_FFFF << n);
            OP_ADD: {cout, result} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_scheduler_arbiter.sv
// Round-robin arbiter: searches ptr+1, ptr+2, ... mod N and grants the first requester found.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] cand_idx [N];
    logic          found;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        logic [IW:0] sum;
        assign sum           = {1'b0, ptr} + (IW+1)'(gi + 1);
        assign cand_idx[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    end

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[cand_idx[k]]) begin
                found   = 1'b1;
                gnt_idx = cand_idx[k];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign any = found;

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU among NUM_REQ requesters with round-robin grant and a one-deep
// registered, tagged response slot that can be drained and refilled in the same cycle.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_sched_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    alu_cmd_t           cmd_arr [NUM_REQ];
    alu_cmd_t           sel_cmd;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    rsp_id_reg;
    logic [31:0]        rsp_result_reg;
    logic               rsp_cout_reg;
    logic [CNT_W-1:0]   op_count_reg;
    logic [31:0]        alu_result;
    logic               alu_cout;
    logic               any_valid;
    logic               rsp_valid;
    logic               slot_free;
    logic               grant_en;
    logic               accept;
    logic               drain;
    state_t             state_reg;
    state_t             state_next;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign cmd_arr[gi] = {bus.req_opcode[3*gi +: 3], bus.req_a[32*gi +: 32],
                              bus.req_b[32*gi +: 32], bus.req_cin[gi]};
    end

    assign rsp_valid = (state_reg == ST_FULL);
    assign slot_free = !rsp_valid || bus.rsp_ready;
    // no grants are offered while reset is held, even though the slot reads empty
    assign grant_en  = slot_free && rst_n;
    assign drain     = rsp_valid && bus.rsp_ready;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_reg),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_valid)
    );

    assign accept        = grant_en && any_valid;
    assign bus.req_ready = gnt;
    assign sel_cmd       = cmd_arr[gnt_idx];

    alu_32bit_unsigned u_alu (
        .opcode (sel_cmd.opcode),
        .a      (sel_cmd.a),
        .b      (sel_cmd.b),
        .cin    (sel_cmd.cin),
        .result (alu_result),
        .cout   (alu_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (accept)           state_next = ST_FULL;
            ST_FULL:  if (drain && !accept) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_reg     <= '0;
            rsp_result_reg <= '0;
            rsp_cout_reg   <= 1'b0;
            rr_ptr_reg     <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            rsp_id_reg     <= gnt_idx;
            rsp_result_reg <= alu_result;
            rsp_cout_reg   <= alu_cout;
            rr_ptr_reg     <= gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_reg <= '0;
        end else if (drain) begin
            op_count_reg <= op_count_reg + 1'b1;
        end
    end

    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = rsp_id_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_cout   = rsp_cout_reg;
    assign bus.op_count   = op_count_reg;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: a driver presents queued commands, a monitor checks responses.
module tb_alu_rr_scheduler;
    import alu_sched_pkg::*;

    localparam int NREQ  = 4;
    localparam int CNT_W = 16;

    typedef struct {
        int          id;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] res;
        logic        cout;
    } cmd_t;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sched_if #(.NUM_REQ(NREQ), .CNT_W(CNT_W)) bus ();

    alu_rr_scheduler #(.NUM_REQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cmd_t cmd_q [$];
    exp_t exp_q [$];
    int   ord_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   chk_gap = 1'b0;
    bit   have_prev = 1'b0;
    int   prev_cyc = 0;
    bit   quiet = 1'b0;
    int   mon_idx;
    int   mon_ord;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic enq(input int id, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cin, input logic [31:0] res,
                       input logic cout);
        cmd_t c;
        c.id = id; c.op = op; c.a = a; c.b = b; c.cin = cin; c.res = res; c.cout = cout;
        cmd_q.push_back(c);
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (cmd_q.size() == 0 && bus.req_valid == '0 && !bus.rsp_valid && exp_q.size() == 0) begin
                idle = 1'b1;
                break;
            end
        end
        chk(name, 32'(idle), 32'd1);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // driver: keeps each requester's command stable until accepted, then loads the next one
    initial begin
        bit   took [NREQ];
        cmd_t c;
        exp_t e;
        bus.req_valid  = '0;
        bus.req_opcode = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_cin    = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) took[i] = rst_n && bus.req_valid[i] && bus.req_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (took[i]) bus.req_valid[i] = 1'b0;
                if (!bus.req_valid[i]) begin
                    for (int k = 0; k < cmd_q.size(); k++) begin
                        if (cmd_q[k].id == i) begin
                            c = cmd_q[k];
                            cmd_q.delete(k);
                            bus.req_opcode[3*i +: 3] = c.op;
                            bus.req_a[32*i +: 32]    = c.a;
                            bus.req_b[32*i +: 32]    = c.b;
                            bus.req_cin[i]           = c.cin;
                            bus.req_valid[i]         = 1'b1;
                            e.id = c.id; e.res = c.res; e.cout = c.cout;
                            exp_q.push_back(e);
                            break;
                        end
                    end
                end
            end
        end
    end

    // monitor: every response handshake is matched against the oldest expectation for its tag
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (!quiet)
                $display("rsp id=%0d result=%h cout=%b op_count=%0d", bus.rsp_id, bus.rsp_result,
                         bus.rsp_cout, bus.op_count);
            mon_idx = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (exp_q[k].id == int'(bus.rsp_id)) begin
                    mon_idx = k;
                    break;
                end
            end
            if (mon_idx < 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got id %0d result %h, expected no response", bus.rsp_id,
                         bus.rsp_result);
            end else begin
                chk("rsp_result", bus.rsp_result, exp_q[mon_idx].res);
                chk("rsp_cout", 32'(bus.rsp_cout), 32'(exp_q[mon_idx].cout));
                exp_q.delete(mon_idx);
            end
            if (ord_q.size() > 0) begin
                mon_ord = ord_q.pop_front();
                chk("rsp_order", 32'(bus.rsp_id), 32'(mon_ord));
            end
            if (chk_gap) begin
                if (have_prev) chk("no_bubble", 32'(cyc - prev_cyc), 32'd1);
                have_prev = 1'b1;
                prev_cyc  = cyc;
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        #7;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("reset_rsp_result", bus.rsp_result, 32'd0);
        chk("reset_rsp_cout", 32'(bus.rsp_cout), 32'd0);
        chk("reset_op_count", 32'(bus.op_count), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // carry-out boundary and one-cycle latency
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        enq(0, OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.req_valid[0] && bus.req_ready[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t1_accept", 32'(seen), 32'd1);
        @(negedge clk);
        chk("t1_latency_valid", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        chk("t1_op_count", 32'(bus.op_count), 32'd1);
        wait_idle("t1_idle");

        // all requesters busy: strict 0,1,2,3 rotation with no bubbles
        reset_dut();
        chk_gap = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                enq(i, OP_XOR, 32'(16*i + r), 32'hFFFF_0000, 1'b0, 32'(16*i + r) ^ 32'hFFFF_0000, 1'b0);
                ord_q.push_back(i);
            end
        end
        wait_idle("t2_idle");
        chk_gap = 1'b0;

        // backpressure: response held, no grants, then rotation resumes after requester 0
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        enq(0, OP_OR,  32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 32'hF0F0_0F0F, 1'b0);
        enq(2, OP_ADD, 32'd10, 32'd20, 1'b0, 32'd30, 1'b0);
        enq(3, OP_AND, 32'hFFFF_0000, 32'h1234_5678, 1'b0, 32'h1234_0000, 1'b0);
        ord_q.push_back(0); ord_q.push_back(2); ord_q.push_back(3);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t3_rsp_seen", 32'(seen), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("t3_hold_id", 32'(bus.rsp_id), 32'd0);
            chk("t3_hold_result", bus.rsp_result, 32'hF0F0_0F0F);
            chk("t3_hold_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_idle("t3_idle");

        // ALU function vectors, including shift/cut boundaries and cin
        enq(1, OP_SHL, 32'h1, 32'h0000_0025, 1'b0, 32'h20, 1'b0);
        enq(2, OP_CUT, 32'hABCD_1234, 32'h0, 1'b0, 32'h0, 1'b0);
        enq(0, OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 32'hF0F0_0F0F, 1'b0);
        enq(3, OP_ADD, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'h0, 1'b1);
        enq(0, OP_SHR, 32'hDEAD_BEEF, 32'h20, 1'b0, 32'hDEAD_BEEF, 1'b0);
        enq(1, OP_SHR, 32'h8000_0000, 32'h4, 1'b0, 32'h0800_0000, 1'b0);
        enq(2, OP_NOT, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b1, 32'hF0F0_F0F0, 1'b0);
        enq(3, OP_ADD, 32'd5, 32'd7, 1'b1, 32'd13, 1'b0);
        enq(3, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 32'h0F00_0F00, 1'b0);
        enq(1, OP_SHL, 32'hFFFF_FFFF, 32'h1F, 1'b0, 32'h8000_0000, 1'b0);
        wait_idle("t4_idle");

        // async reset while a response is held
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        enq(1, OP_XOR, 32'h1, 32'h3, 1'b0, 32'h2, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_rsp_seen", 32'(seen), 32'd1);
        enq(0, OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        enq(2, OP_SHL, 32'h8000_0001, 32'h1, 1'b0, 32'h2, 1'b0);
        ord_q.push_back(0); ord_q.push_back(2);
        repeat (2) @(negedge clk);
        chk("t5_stall_req_ready", 32'(bus.req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t5_reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("t5_reset_rsp_result", bus.rsp_result, 32'd0);
        chk("t5_reset_op_count", 32'(bus.op_count), 32'd0);
        chk("t5_reset_req_ready", 32'(bus.req_ready), 32'd0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k].id == 1) begin
                exp_q.delete(k);
                break;
            end
        end
        @(posedge clk);
        #3;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b1;
        wait_idle("t5_idle");
        chk("t5_op_count", 32'(bus.op_count), 32'd2);

        // counter wrap after 2^CNT_W-1 handshakes
        reset_dut();
        quiet = 1'b1;
        for (int k = 0; k < (1 << CNT_W) - 1; k++) begin
            while (cmd_q.size() >= NREQ) @(posedge clk);
            enq(k % NREQ, OP_XOR, 32'(k), 32'h5A5A_5A5A, 1'b0, 32'(k) ^ 32'h5A5A_5A5A, 1'b0);
        end
        wait_idle("t6_idle_full");
        chk("t6_op_count_max", 32'(bus.op_count), 32'h0000_FFFF);
        quiet = 1'b0;
        enq(2, OP_OR, 32'h0000_00F0, 32'h0000_000F, 1'b0, 32'h0000_00FF, 1'b0);
        wait_idle("t6_idle_wrap");
        chk("t6_op_count_wrap", 32'(bus.op_count), 32'd0);
        chk("order_queue_empty", 32'(ord_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
